regfile_param: RTL and testbench

REGFILE_PARAM -- requirements
Module: regfile_param

---
 rtl/regfile_param.sv | 105 ++++++++++
 tb/tb_regfile_param.sv | 223 ++++++++++++++++++++++
 2 files changed

// File: rtl/regfile_param.sv
// Parameterised 2-read/1-write register file with FSM-driven array clear and
// optional write-to-read bypass (define REGFILE_BYPASS_EN to enable).
module regfile_param #(
    parameter int XLEN     = 64,
    parameter int NREG     = 32,
    parameter int ZERO_REG = 1,
    localparam int AW      = $clog2(NREG)
) (
    input  logic            clk,
    input  logic            rst_n,
    input  logic            we,
    input  logic [AW-1:0]   waddr,
    input  logic [XLEN-1:0] wdata,
    input  logic [AW-1:0]   raddr1,
    input  logic [AW-1:0]   raddr2,
    output logic [XLEN-1:0] rdata1,
    output logic [XLEN-1:0] rdata2,
    input  logic            clr_req,
    output logic            busy
);

    localparam logic [0:0]  ST_IDLE  = 1'b0;
    localparam logic [0:0]  ST_CLEAR = 1'b1;
    localparam logic [AW:0] PTR_LAST = (AW+1)'(NREG - 1);

    logic [0:0]      state;
    logic [AW:0]     ptr;
    logic [XLEN-1:0] mem [NREG];

    logic            zero_hit;
    logic            wr_ok;
    logic            mem_we;
    logic [AW-1:0]   mem_waddr;
    logic [XLEN-1:0] mem_wdata;

    assign busy     = (state == ST_CLEAR);
    assign zero_hit = (ZERO_REG != 0) && (waddr == '0);
    // A user write survives only in IDLE, outside reset, without a clear request.
    assign wr_ok    = rst_n && (state == ST_IDLE) && we && !clr_req && !zero_hit;

    always_comb begin
        mem_we    = 1'b0;
        mem_waddr = waddr;
        mem_wdata = wdata;
        if (state == ST_CLEAR) begin
            mem_we    = rst_n;
            mem_waddr = ptr[AW-1:0];
            mem_wdata = '0;
        end else if (wr_ok) begin
            mem_we = 1'b1;
        end
    end

    always_ff @(posedge clk) begin
        if (!rst_n) begin
            state <= ST_CLEAR;
            ptr   <= '0;
        end else begin
            case (state)
                ST_CLEAR: begin
                    ptr <= ptr + 1'b1;
                    if (ptr == PTR_LAST) begin
                        state <= ST_IDLE;
                    end
                end
                default: begin
                    if (clr_req) begin
                        state <= ST_CLEAR;
                        ptr   <= '0;
                    end
                end
            endcase
        end
    end

    always_ff @(posedge clk) begin
        if (mem_we) begin
            mem[mem_waddr] <= mem_wdata;
        end
    end

    // Priority: busy masking, then the hardwired zero, then bypass, then the array.
    function automatic logic [XLEN-1:0] read_port(input logic [AW-1:0] addr);
        logic [XLEN-1:0] val;
        if (busy) begin
            val = '0;
        end else if ((ZERO_REG != 0) && (addr == '0)) begin
            val = '0;
        end else begin
            val = mem[addr];
`ifdef REGFILE_BYPASS_EN
            if (wr_ok && (addr == waddr)) begin
                val = wdata;
            end
`endif
        end
        return val;
    endfunction

    always_comb begin
        rdata1 = read_port(raddr1);
        rdata2 = read_port(raddr2);
    end

endmodule

// File: tb/tb_regfile_param.sv
// Directed bench for regfile_param with a per-cycle reference model check.
module tb_regfile_param;

    localparam int XLEN = 64;
    localparam int NREG = 32;
    localparam int AW   = 5;
`ifdef REGFILE_BYPASS_EN
    localparam bit BYPASS = 1'b1;
`else
    localparam bit BYPASS = 1'b0;
`endif

    logic            clk = 1'b0;
    logic            rst_n;
    logic            we;
    logic [AW-1:0]   waddr;
    logic [XLEN-1:0] wdata;
    logic [AW-1:0]   raddr1;
    logic [AW-1:0]   raddr2;
    logic [XLEN-1:0] rdata1;
    logic [XLEN-1:0] rdata2;
    logic            clr_req;
    logic            busy;

    int n_cmp = 0;
    int n_bad = 0;

    regfile_param #(
        .XLEN(XLEN),
        .NREG(NREG),
        .ZERO_REG(1)
    ) dut (
        .clk(clk),
        .rst_n(rst_n),
        .we(we),
        .waddr(waddr),
        .wdata(wdata),
        .raddr1(raddr1),
        .raddr2(raddr2),
        .rdata1(rdata1),
        .rdata2(rdata2),
        .clr_req(clr_req),
        .busy(busy)
    );

    always #5 clk = ~clk;

    // Reference model: contents plus number of clear cycles still to run.
    logic [XLEN-1:0] mem_m [NREG];
    int              clr_left = 0;
    bit              model_valid = 1'b0;

    always @(posedge clk) begin
        if (!rst_n) begin
            model_valid = 1'b1;
            clr_left    = NREG;
            for (int i = 0; i < NREG; i++) mem_m[i] = '0;
        end else if (clr_left > 0) begin
            clr_left = clr_left - 1;
        end else if (clr_req) begin
            clr_left = NREG;
            for (int i = 0; i < NREG; i++) mem_m[i] = '0;
        end else if (we && waddr != 0) begin
            mem_m[waddr] = wdata;
        end
    end

    function automatic logic [XLEN-1:0] exp_rd(input logic [AW-1:0] a);
        if (clr_left > 0 || a == 0) return '0;
        if (BYPASS && rst_n && we && !clr_req && waddr != 0 && a == waddr) return wdata;
        return mem_m[a];
    endfunction

    always @(negedge clk) begin
        if (model_valid) begin
            n_cmp++;
            if (busy !== (clr_left > 0)) begin
                n_bad++;
                $display("FAIL model_busy t=%0t got=%0b exp=%0b", $time, busy, clr_left > 0);
            end
            n_cmp++;
            if (rdata1 !== exp_rd(raddr1)) begin
                n_bad++;
                $display("FAIL model_rdata1 t=%0t addr=%0d got=%h exp=%h", $time, raddr1, rdata1, exp_rd(raddr1));
            end
            n_cmp++;
            if (rdata2 !== exp_rd(raddr2)) begin
                n_bad++;
                $display("FAIL model_rdata2 t=%0t addr=%0d got=%h exp=%h", $time, raddr2, rdata2, exp_rd(raddr2));
            end
        end
    end

    task automatic step();
        @(posedge clk);
        #1;
    endtask

    task automatic check(input string name, input logic [XLEN-1:0] got, input logic [XLEN-1:0] exp);
        n_cmp++;
        if (got !== exp) begin
            n_bad++;
            $display("FAIL %s got=%h exp=%h", name, got, exp);
        end
    endtask

    task automatic count_busy(output int cnt);
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            step();
        end
    endtask

    task automatic check_all_zero(input string name);
        for (int r = 0; r < NREG; r++) begin
            step();
            raddr1 = AW'(r);
            raddr2 = AW'(NREG - 1 - r);
            @(negedge clk);
            check(name, rdata1, '0);
            check(name, rdata2, '0);
        end
    endtask

    localparam logic [XLEN-1:0] PAT = 64'hDEAD_BEEF_0123_4567;

    initial begin
        int cnt;
        rst_n = 1'b0; we = 1'b0; waddr = '0; wdata = '0;
        raddr1 = '0; raddr2 = '0; clr_req = 1'b0;

        // Reset for two cycles, then a full 32-cycle clear.
        step();
        raddr1 = 5'd5; raddr2 = 5'd9;
        @(negedge clk);
        check("reset_busy", {63'd0, busy}, 64'd1);
        check("reset_rdata1", rdata1, '0);
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        check("reset_busy_len", 64'(cnt), 64'd32);
        check_all_zero("reset_zero");

        // Write then read on both ports.
        step();
        we = 1'b1; waddr = 5'd5; wdata = PAT;
        step();
        we = 1'b0; raddr1 = 5'd5; raddr2 = 5'd5;
        @(negedge clk);
        check("wr_rd_port1", rdata1, PAT);
        check("wr_rd_port2", rdata2, PAT);

        // Writes to register 0 are dropped.
        step();
        we = 1'b1; waddr = 5'd0; wdata = '1; raddr1 = 5'd0;
        step();
        we = 1'b0;
        @(negedge clk);
        check("reg0_read", rdata1, '0);

        // Same-cycle read of the register being written.
        step();
        we = 1'b1; waddr = 5'd7; wdata = 64'h1234; raddr1 = 5'd7; raddr2 = 5'd5;
        @(negedge clk);
        check("bypass_same_cycle", rdata1, BYPASS ? 64'h1234 : 64'h0);
        check("bypass_other_port", rdata2, PAT);
        step();
        we = 1'b0;
        @(negedge clk);
        check("bypass_next_cycle", rdata1, 64'h1234);

        // Clear during use; writes and clr_req during busy are ignored.
        for (int r = 1; r <= 3; r++) begin
            step();
            we = 1'b1; waddr = AW'(r); wdata = 64'(r) * 64'h1111_0000_0000_0011;
        end
        step();
        we = 1'b0; raddr1 = 5'd2; raddr2 = 5'd3;
        @(negedge clk);
        check("pre_clear_r2", rdata1, 64'h2222_0000_0000_0022);
        check("pre_clear_r3", rdata2, 64'h3333_0000_0000_0033);
        step();
        clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        we = 1'b1; waddr = 5'd3; wdata = 64'hFFFF;
        cnt = 0;
        for (int i = 0; i < 100; i++) begin
            @(negedge clk);
            if (!busy) break;
            cnt++;
            step();
            clr_req = (cnt == 5);
        end
        we = 1'b0; clr_req = 1'b0;
        check("clear_busy_len", 64'(cnt), 64'd32);
        check_all_zero("clear_zero");

        // Reset asserted at clear cycle 10 restarts the clear.
        step();
        we = 1'b1; waddr = 5'd9; wdata = 64'hABCD;
        step();
        we = 1'b0; clr_req = 1'b1;
        step();
        clr_req = 1'b0;
        for (int i = 0; i < 10; i++) step();
        rst_n = 1'b0;
        @(negedge clk);
        check("midclr_busy", {63'd0, busy}, 64'd1);
        step();
        rst_n = 1'b1;
        count_busy(cnt);
        check("midclr_busy_len", 64'(cnt), 64'd32);
        check_all_zero("midclr_zero");

        $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
        $finish;
    end

endmodule
